dpi_ram_bridge: RTL and testbench
=================================

// Module: dpi_ram_bridge
// PURPOSE
//   Multi-port successor to the single-port DPI RAM helper in the difftest sim top.
//   NR_RPORT independent read ports + 1 write port onto the C-side memory
//   (ram_read_helper / ram_write_helper). Adds valid/ready handshakes, a RD_LAT-deep
//   read pipeline per port with backpressure, parametrised base/size window,
//   out-of-range error reporting and a saturating error counter. Simulation only.
// PARAMETERS
//   NR_RPORT   2               number of read ports (1..4)
//   BASE_ADDR  64'h8000_0000   byte address mapped to DPI index 0
//   MEM_BYTES  64'h0800_0000   window size in bytes; valid range [BASE, BASE+MEM_BYTES)
//   RD_LAT     1               read pipeline stages, accept -> rresp_valid (1..4)
// PORTS
//   clk         in   1            clock
//   rst         in   1            async reset, active-high
//   rreq_valid  in   NR_RPORT     read request valid, one bit per port
//   rreq_ready  out  NR_RPORT     read request ready
//   rreq_addr   in   64*NR_RPORT  byte address; port p = [64p+63:64p]
//   rresp_valid out  NR_RPORT     read data valid
//   rresp_ready in   NR_RPORT     read data consumed
//   rresp_data  out  64*NR_RPORT  aligned 64-bit read data
//   rresp_err   out  NR_RPORT     address outside window; data is 0
//   wreq_valid  in   1            write request valid
//   wreq_ready  out  1            write ready; 1 whenever rst is low
//   wreq_addr   in   64           byte address
//   wreq_data   in   64           write data
//   wreq_strb   in   8            byte strobe; bit i -> byte i
//   err_cnt     out  16           saturating count of rejected reads+writes
// BEHAVIOUR
//   - Reset (async): all pipeline valids, rresp_valid, rresp_data, rresp_err, err_cnt -> 0;
//     wreq_ready=0, rreq_ready=0 while rst high. No DPI call while rst is high.
//     Reset mid-operation discards in-flight reads; writes already issued stay in memory.
//   - Index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored (dword aligned).
//   - In range: BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES, compared on full 64 bits
//     (no wrap: addr < BASE is out of range, never negative index).
//   - Read accept: rreq_valid[p] & rreq_ready[p] at posedge. In range: ram_read_helper(1, idx)
//     called at that edge, result into stage 0. Out of range: no DPI call, data 0, err 1.
//   - Pipeline: stage k advances when stage k+1 empty or advancing; last stage advances
//     on rresp_ready. rreq_ready[p] = ~stage0_valid | stage0_advance. Zero-bubble:
//     with rresp_ready held 1, one read per port per cycle, latency exactly RD_LAT.
//   - rresp_valid/data/err held stable while rresp_valid & ~rresp_ready.
//   - Write accept: wreq_valid & wreq_ready. In range: ram_write_helper(idx, wreq_data,
//     bitmask, 1) where bitmask byte i = {8{wreq_strb[i]}}. strb==0 -> DPI call skipped.
//     Out of range: dropped, counted.
//   - Same-edge ordering: all port reads issued before the write -> reads of the written
//     index return pre-write data (unless RAM_RW_FWD_EN).
//   - err_cnt += (#rejected reads + rejected write) per cycle; saturates at 16'hFFFF.
// CONFIGURATION
//   RAM_RW_FWD_EN defined: a read accepted on the same edge as an in-range write to the
//     same index returns (wdata & bitmask) | (old & ~bitmask) — post-write view.
//   Not defined: pre-write data returned as above; no comparator logic generated.
// TESTING
//   1 Reset: rst=1 with rreq_valid=all 1 -> no DPI calls, rresp_valid=0, err_cnt=0, ready=0.
//   2 Write 0x8000_0010 data 64'h1122_3344_5566_7788 strb 8'h0F, then read port0
//     -> 64'h0000_0000_5566_7788 (mem pre-zeroed) after exactly RD_LAT cycles, err=0.
//   3 Read 0x7FFF_FFF8 and 0x8800_0000 (NR_RPORT=2, default size) -> both err=1, data 0,
//     err_cnt=2; write to 0x8800_0000 -> dropped, err_cnt=3.
//   4 Backpressure RD_LAT=2: stream 8 reads port1, rresp_ready low 3 cycles -> no loss,
//     order kept, rreq_ready drops after 2 fills, stream resumes 1/cycle.
//   5 Same-edge read+write index 4: old 0, wdata 64'hAA.., strb FF -> 0 without
//     RAM_RW_FWD_EN, 64'hAAAA_AAAA_AAAA_AAAA with it.
//   6 Assert rst with 2 reads in flight -> rresp_valid=0 next cycle, no stale response after.

Source files
------------

// File: rtl/dpi_ram_bridge.sv
// Multi-port simulation RAM bridge with NR_RPORT read pipelines and one write port.
// Optional macro RAM_RW_FWD_EN: a same-edge read of the index being written returns post-write data.
module dpi_ram_bridge #(
  parameter int unsigned NR_RPORT  = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0800_0000,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NR_RPORT-1:0]    rreq_valid_i,
  output logic [NR_RPORT-1:0]    rreq_ready_o,
  input  logic [64*NR_RPORT-1:0] rreq_addr_i,
  output logic [NR_RPORT-1:0]    rresp_valid_o,
  input  logic [NR_RPORT-1:0]    rresp_ready_i,
  output logic [64*NR_RPORT-1:0] rresp_data_o,
  output logic [NR_RPORT-1:0]    rresp_err_o,
  input  logic                   wreq_valid_i,
  output logic                   wreq_ready_o,
  input  logic [63:0]            wreq_addr_i,
  input  logic [63:0]            wreq_data_i,
  input  logic [7:0]             wreq_strb_i,
  output logic [15:0]            err_cnt_o
);

  // C-side memory; absent entries read as zero.
  bit [63:0] c_mem [bit [63:0]];

  function automatic logic [63:0] ram_read_helper(input logic rd_en, input logic [63:0] rd_idx);
    if (rd_en && c_mem.exists(rd_idx)) return c_mem[rd_idx];
    return '0;
  endfunction

  function automatic void ram_write_helper(input logic [63:0] wr_idx, input logic [63:0] wr_data,
                                           input logic [63:0] wr_mask, input logic wr_en);
    logic [63:0] old;
    if (wr_en) begin
      old = ram_read_helper(1'b1, wr_idx);
      c_mem[wr_idx] = (wr_data & wr_mask) | (old & ~wr_mask);
    end
  endfunction

  // Subtract first so BASE_ADDR + MEM_BYTES never has to be formed.
  function automatic logic in_window(input logic [63:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < MEM_BYTES);
  endfunction

  // go[k]: stage k can take new data this edge; go[RD_LAT] is the consumer.
  function automatic logic [RD_LAT:0] calc_go(input logic [RD_LAT-1:0] vld, input logic rdy);
    logic [RD_LAT:0] g;
    g = '0;
    g[RD_LAT] = rdy;
    for (int k = RD_LAT - 1; k >= 0; k--) g[k] = ~vld[k] | g[k+1];
    return g;
  endfunction

  logic [RD_LAT-1:0] vld_q  [NR_RPORT];
  logic [63:0]       data_q [NR_RPORT][RD_LAT];
  logic              err_q  [NR_RPORT][RD_LAT];
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic [RD_LAT:0]     go    [NR_RPORT];
  logic [NR_RPORT-1:0] r_acc, r_win;
  logic [63:0]         r_idx [NR_RPORT];
  logic                w_acc, w_win, w_do;
  logic [63:0]         w_idx, w_mask;
  logic [2:0]          n_rej;
  logic [16:0]         cnt_sum;

  always_comb begin
    n_rej = '0;
    for (int p = 0; p < NR_RPORT; p++) begin
      go[p]            = calc_go(vld_q[p], rresp_ready_i[p]);
      rreq_ready_o[p]  = ~rst_i & go[p][0];
      r_acc[p]         = rreq_valid_i[p] & rreq_ready_o[p];
      r_win[p]         = in_window(rreq_addr_i[64*p +: 64]);
      r_idx[p]         = (rreq_addr_i[64*p +: 64] - BASE_ADDR) >> 3;
      rresp_valid_o[p] = vld_q[p][RD_LAT-1];
      rresp_data_o[64*p +: 64] = data_q[p][RD_LAT-1];
      rresp_err_o[p]   = err_q[p][RD_LAT-1];
      n_rej            = n_rej + 3'(r_acc[p] & ~r_win[p]);
    end
    wreq_ready_o = ~rst_i;
    w_acc  = wreq_valid_i & wreq_ready_o;
    w_win  = in_window(wreq_addr_i);
    w_idx  = (wreq_addr_i - BASE_ADDR) >> 3;
    w_do   = w_acc & w_win & (|wreq_strb_i);
    w_mask = '0;
    for (int i = 0; i < 8; i++) w_mask[8*i +: 8] = {8{wreq_strb_i[i]}};
    n_rej     = n_rej + 3'(w_acc & ~w_win);
    cnt_sum   = {1'b0, err_cnt_q} + 17'(n_rej);
    err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

`ifdef RAM_RW_FWD_EN
  function automatic logic [63:0] fetch(input logic [63:0] idx);
    logic [63:0] old;
    old = ram_read_helper(1'b1, idx);
    if (w_do && (idx == w_idx)) return (wreq_data_i & w_mask) | (old & ~w_mask);
    return old;
  endfunction
`else
  function automatic logic [63:0] fetch(input logic [63:0] idx);
    return ram_read_helper(1'b1, idx);
  endfunction
`endif

  assign err_cnt_o = err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
      for (int p = 0; p < NR_RPORT; p++) begin
        vld_q[p] <= '0;
        for (int k = 0; k < RD_LAT; k++) begin
          data_q[p][k] <= '0;
          err_q[p][k]  <= 1'b0;
        end
      end
    end else begin
      err_cnt_q <= err_cnt_d;
      for (int p = 0; p < NR_RPORT; p++) begin
        for (int k = 1; k < RD_LAT; k++) begin
          if (go[p][k]) begin
            vld_q[p][k]  <= vld_q[p][k-1];
            data_q[p][k] <= data_q[p][k-1];
            err_q[p][k]  <= err_q[p][k-1];
          end
        end
        if (go[p][0]) begin
          vld_q[p][0] <= r_acc[p];
          if (r_acc[p]) begin
            data_q[p][0] <= r_win[p] ? fetch(r_idx[p]) : '0;
            err_q[p][0]  <= ~r_win[p];
          end
        end
      end
      // Issued after all port reads so same-edge reads see pre-write contents.
      ram_write_helper(w_idx, wreq_data_i, w_mask, w_do);
    end
  end

endmodule

// File: tb/tb_dpi_ram_bridge.sv
// Directed self-checking bench for dpi_ram_bridge (NR_RPORT=2, RD_LAT=2).
module tb_dpi_ram_bridge;

  localparam int unsigned NR  = 2;
  localparam int unsigned LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   rreq_valid, rreq_ready, rresp_valid, rresp_ready, rresp_err;
  logic [64*NR-1:0] rreq_addr, rresp_data;
  logic            wreq_valid, wreq_ready;
  logic [63:0]     wreq_addr, wreq_data;
  logic [7:0]      wreq_strb;
  logic [15:0]     err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpi_ram_bridge #(
    .NR_RPORT (NR),
    .BASE_ADDR(64'h8000_0000),
    .MEM_BYTES(64'h0800_0000),
    .RD_LAT   (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rreq_valid_i (rreq_valid),
    .rreq_ready_o (rreq_ready),
    .rreq_addr_i  (rreq_addr),
    .rresp_valid_o(rresp_valid),
    .rresp_ready_i(rresp_ready),
    .rresp_data_o (rresp_data),
    .rresp_err_o  (rresp_err),
    .wreq_valid_i (wreq_valid),
    .wreq_ready_o (wreq_ready),
    .wreq_addr_i  (wreq_addr),
    .wreq_data_i  (wreq_data),
    .wreq_strb_i  (wreq_strb),
    .err_cnt_o    (err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rreq_valid  = '0;
    rresp_ready = '1;
    wreq_valid  = 1'b0;
    wreq_strb   = 8'h00;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int sent, recv, last_c, low_cnt, resume_c;
    logic rq, acc, rv;
    logic [63:0] rd;

    vecs[0] = '{64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 64'h0000_0000_5566_7788, 0, 0};
    vecs[1] = '{64'h8000_0014, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 64'hFFFF_FFFF_5566_7788, 0, 0};
    vecs[2] = '{64'h8000_0100, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0};
    vecs[3] = '{64'h8000_0200, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 64'h0, 0, 0};
    vecs[4] = '{64'h87FF_FFF8, 64'hCAFE_BABE_1234_5678, 8'h81, 64'hCA00_0000_0000_0078, 0, 0};
    vecs[5] = '{64'h8800_0000, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 1, 2};
    vecs[6] = '{64'h7FFF_FFF8, 64'h6666_6666_6666_6666, 8'hFF, 64'h0, 1, 4};
    vecs[7] = '{64'h1_8000_0010, 64'h7777_7777_7777_7777, 8'hFF, 64'h0, 1, 6};
    vecs[8] = '{64'h8000_0010, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 0, 6};

    // Reset with requests pending: nothing accepted, nothing written.
    rst = 1'b1;
    rreq_valid = '1;
    rresp_ready = '1;
    rreq_addr = {64'h8000_0200, 64'h8000_0200};
    wreq_valid = 1'b1;
    wreq_addr = 64'h8000_0200;
    wreq_data = '1;
    wreq_strb = 8'hFF;
    tick();
    tick();
    chk("rst_rreq_ready", 64'(rreq_ready), 64'h0);
    chk("rst_wreq_ready", 64'(wreq_ready), 64'h0);
    chk("rst_rresp_valid", 64'(rresp_valid), 64'h0);
    chk("rst_err_cnt", 64'(err_cnt), 64'h0);
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_wreq_ready", 64'(wreq_ready), 64'h1);
    chk("post_rst_rreq_ready", 64'(rreq_ready), 64'h3);
    tick();

    // Write then read back on port 0, table driven.
    for (int i = 0; i < 9; i++) begin
      wreq_valid = 1'b1;
      wreq_addr  = vecs[i].addr;
      wreq_data  = vecs[i].wdata;
      wreq_strb  = vecs[i].strb;
      tick();
      idle();
      rreq_valid[0]     = 1'b1;
      rreq_addr[63:0]   = vecs[i].addr;
      tick();
      idle();
      chk($sformatf("v%0d_early_valid", i), 64'(rresp_valid[0]), 64'h0);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(rresp_valid[0]), 64'h1);
      chk($sformatf("v%0d_data", i), rresp_data[63:0], vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), 64'(rresp_err[0]), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(vecs[i].exp_cnt));
      tick();
    end

    // Two out-of-range reads on the same edge, then an out-of-range write.
    rreq_valid = 2'b11;
    rreq_addr  = {64'h8800_0000, 64'h7FFF_FFF8};
    tick();
    idle();
    tick();
    chk("dual_err_valid", 64'(rresp_valid), 64'h3);
    chk("dual_err_data", rresp_data[63:0] | rresp_data[127:64], 64'h0);
    chk("dual_err_flags", 64'(rresp_err), 64'h3);
    chk("dual_err_cnt", 64'(err_cnt), 64'd8);
    wreq_valid = 1'b1;
    wreq_addr  = 64'h8800_0000;
    wreq_data  = '1;
    wreq_strb  = 8'hFF;
    tick();
    idle();
    chk("oor_write_cnt", 64'(err_cnt), 64'd9);
    tick();

    // Preload eight words for the port 1 stream.
    for (int i = 0; i < 8; i++) begin
      wreq_valid = 1'b1;
      wreq_addr  = 64'h8000_1000 + 64'(8 * i);
      wreq_data  = 64'hA000 + 64'(i);
      wreq_strb  = 8'hFF;
      tick();
    end
    idle();
    tick();

    // Stream with consumer stalled in cycles 4..6.
    sent = 0; recv = 0; last_c = -1; low_cnt = 0; resume_c = -1;
    for (int c = 0; c < 30 && recv < 8; c++) begin
      rreq_valid[1]      = (sent < 8);
      rreq_addr[127:64]  = 64'h8000_1000 + 64'(8 * sent);
      rresp_ready[1]     = !(c >= 4 && c <= 6);
      #1;
      rq  = rreq_ready[1];
      acc = rreq_valid[1] & rq;
      rv  = rresp_valid[1] & rresp_ready[1];
      rd  = rresp_data[127:64];
      if (!rq) low_cnt++;
      if (acc && sent == 4) resume_c = c;
      tick();
      if (acc) sent++;
      if (rv) begin
        chk($sformatf("stream_data%0d", recv), rd, 64'hA000 + 64'(recv));
        recv++;
        last_c = c;
      end
    end
    idle();
    chk("stream_count", 64'(recv), 64'd8);
    chk("stream_last_cycle", 64'(last_c), 64'd12);
    chk("stream_ready_low_cycles", 64'(low_cnt), 64'd3);
    chk("stream_resume_cycle", 64'(resume_c), 64'd7);
    tick();
    tick();

    // Same-edge read and write to index 4 (previously unwritten).
    rreq_valid[0]   = 1'b1;
    rreq_addr[63:0] = 64'h8000_0020;
    wreq_valid = 1'b1;
    wreq_addr  = 64'h8000_0020;
    wreq_data  = 64'hAAAA_AAAA_AAAA_AAAA;
    wreq_strb  = 8'hFF;
    tick();
    idle();
    tick();
`ifdef RAM_RW_FWD_EN
    chk("same_edge_data", rresp_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
`else
    chk("same_edge_data", rresp_data[63:0], 64'h0);
`endif
    tick();
    rreq_valid[0] = 1'b1;
    tick();
    idle();
    tick();
    chk("after_write_data", rresp_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
    tick();

    // Reset with two reads in flight.
    rreq_valid[0]   = 1'b1;
    rreq_addr[63:0] = 64'h8000_0100;
    tick();
    tick();
    idle();
    chk("inflight_valid_before_rst", 64'(rresp_valid[0]), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(rresp_valid), 64'h0);
    chk("rst_async_cnt", 64'(err_cnt), 64'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("no_stale_%0d", i), 64'(rresp_valid), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
